// File: rtl/seq_det_pkg.sv
// Shared helpers for the serial pattern detector: state width and the
// compile-time prefix/suffix (KMP) transition rule.
package seq_det_pkg;

    function automatic int state_w(input int len);
        return $clog2(len + 1);
    endfunction

    // Longest pattern prefix that is a suffix of (first s pattern bits, then b).
    // pattern[len-1] is the first bit of the pattern.
    function automatic int next_state(input logic [15:0] pattern, input int len,
                                      input int s, input logic b);
        int   res;
        int   ti;
        logic ok;
        logic tbit;
        res = 0;
        for (int k = 1; k <= 16; k++) begin
            if (k <= len && k <= s + 1) begin
                ok = 1'b1;
                for (int j = 0; j < 16; j++) begin
                    if (j < k) begin
                        ti   = s + 1 - k + j;
                        tbit = (ti < s) ? pattern[len-1-ti] : b;
                        if (tbit != pattern[len-1-j]) ok = 1'b0;
                    end
                end
                if (ok) res = k;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         sat
);
    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    assign sat = &q_q;
    assign q   = q_q;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && !sat) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) q_q <= '0;
        else       q_q <= q_d;
    end

endmodule

// File: rtl/seq_detector.sv
// Moore serial pattern detector with optional overlap, sample enable,
// synchronous clear and a saturating match counter.
module seq_detector
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1100,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             din,
    input  logic             overlap,
    input  logic             clear,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);
    localparam int             SW   = state_w(PAT_LEN);
    localparam int             NS   = 1 << SW;
    localparam logic [SW-1:0]  LAST = SW'(PAT_LEN);

    logic [SW-1:0] state_q;
    logic [SW-1:0] state_d;
    logic [SW-1:0] tab0 [NS];
    logic [SW-1:0] tab1 [NS];
    logic          inc;

    // Transition table built at elaboration; unused encodings fall back to 0.
    genvar gi;
    generate
        for (gi = 0; gi < NS; gi++) begin : g_tab
            if (gi <= PAT_LEN) begin : g_legal
                localparam int N0 = next_state(16'(PATTERN), PAT_LEN, gi, 1'b0);
                localparam int N1 = next_state(16'(PATTERN), PAT_LEN, gi, 1'b1);
                assign tab0[gi] = SW'(N0);
                assign tab1[gi] = SW'(N1);
            end else begin : g_illegal
                assign tab0[gi] = '0;
                assign tab1[gi] = '0;
            end
        end
    endgenerate

    always_comb begin
        state_d = din ? tab1[state_q] : tab0[state_q];
        if (state_q == LAST && !overlap) begin
            state_d = (din == PATTERN[PAT_LEN-1]) ? SW'(1) : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      state_q <= '0;
        else if (clear) state_q <= '0;
        else if (en)    state_q <= state_d;
    end

    assign match = (state_q == LAST);
    assign inc   = en && !clear && (state_d == LAST);

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (inc),
        .q     (match_count),
        .sat   (count_sat)
    );

endmodule

// File: tb/tb_seq_detector.sv
// Table-driven bench for seq_detector over three configurations, with a
// scoreboard queue of expected outputs and hand-written reset/clear corners.
module tb_seq_detector;
    import seq_det_pkg::*;

    localparam int SEL_A = 0;  // 1100, 8-bit counter
    localparam int SEL_B = 1;  // 1010, 8-bit counter
    localparam int SEL_C = 2;  // 1100, 2-bit counter

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0, din = 1'b0, overlap = 1'b1, clear = 1'b0;

    logic       ma, mb, mc, sa, sb_o, sc;
    logic [7:0] ca, cb;
    logic [1:0] cc;

    always #5 clk = ~clk;

    seq_detector #(.PAT_LEN(4), .PATTERN(4'b1100), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .en(en), .din(din), .overlap(overlap), .clear(clear),
        .match(ma), .match_count(ca), .count_sat(sa));
    seq_detector #(.PAT_LEN(4), .PATTERN(4'b1010), .CNT_W(8)) dut_b (
        .clk(clk), .reset(reset), .en(en), .din(din), .overlap(overlap), .clear(clear),
        .match(mb), .match_count(cb), .count_sat(sb_o));
    seq_detector #(.PAT_LEN(4), .PATTERN(4'b1100), .CNT_W(2)) dut_c (
        .clk(clk), .reset(reset), .en(en), .din(din), .overlap(overlap), .clear(clear),
        .match(mc), .match_count(cc), .count_sat(sc));

    typedef struct {
        int   sel;
        logic en, din, ovl, clr;
        logic em;
        int   ec;
        logic es;
    } vec_t;

    typedef struct {
        int   sel;
        int   idx;
        logic em;
        int   ec;
        logic es;
    } exp_t;

    vec_t vt [200];
    int   nv = 0;
    exp_t sbq [$];
    int   total = 0;
    int   bad = 0;
    int   tr = 0;

    function automatic void add(int sel, logic e, logic d, logic o, logic c,
                                logic em, int ec, logic es);
        vt[nv] = '{sel, e, d, o, c, em, ec, es};
        nv++;
    endfunction

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic apply(int sel, logic e, logic d, logic o, logic c,
                         logic em, int ec, logic es);
        exp_t x;
        logic am, as;
        int   ac;
        en = e; din = d; overlap = o; clear = c;
        sbq.push_back('{sel, tr, em, ec, es});
        @(posedge clk);
        #1;
        x = sbq.pop_front();
        case (x.sel)
            SEL_A:   begin am = ma; ac = int'(ca); as = sa;   end
            SEL_B:   begin am = mb; ac = int'(cb); as = sb_o; end
            default: begin am = mc; ac = int'(cc); as = sc;   end
        endcase
        $display("txn %0d dut=%0d en=%b din=%b ovl=%b clr=%b -> match=%b cnt=%0d sat=%b",
                 x.idx, x.sel, e, d, o, c, am, ac, as);
        chk($sformatf("match[%0d]", x.idx), int'(am), int'(x.em));
        chk($sformatf("count[%0d]", x.idx), ac, x.ec);
        chk($sformatf("sat[%0d]", x.idx), int'(as), int'(x.es));
        tr++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        // 1100 with overlap: matches after samples 4 and 8
        add(SEL_A, 1, 0, 1, 1, 0, 0, 0);
        add(SEL_A, 1, 1, 1, 0, 0, 0, 0);
        add(SEL_A, 1, 1, 1, 0, 0, 0, 0);
        add(SEL_A, 1, 0, 1, 0, 0, 0, 0);
        add(SEL_A, 1, 0, 1, 0, 1, 1, 0);
        add(SEL_A, 1, 1, 1, 0, 0, 1, 0);
        add(SEL_A, 1, 1, 1, 0, 0, 1, 0);
        add(SEL_A, 1, 0, 1, 0, 0, 1, 0);
        add(SEL_A, 1, 0, 1, 0, 1, 2, 0);
        // 1010 overlapping: matches after samples 4 and 6
        add(SEL_B, 1, 0, 1, 1, 0, 0, 0);
        add(SEL_B, 1, 1, 1, 0, 0, 0, 0);
        add(SEL_B, 1, 0, 1, 0, 0, 0, 0);
        add(SEL_B, 1, 1, 1, 0, 0, 0, 0);
        add(SEL_B, 1, 0, 1, 0, 1, 1, 0);
        add(SEL_B, 1, 1, 1, 0, 0, 1, 0);
        add(SEL_B, 1, 0, 1, 0, 1, 2, 0);
        // 1010 non-overlapping: only sample 4 matches
        add(SEL_B, 1, 0, 0, 1, 0, 0, 0);
        add(SEL_B, 1, 1, 0, 0, 0, 0, 0);
        add(SEL_B, 1, 0, 0, 0, 0, 0, 0);
        add(SEL_B, 1, 1, 0, 0, 0, 0, 0);
        add(SEL_B, 1, 0, 0, 0, 1, 1, 0);
        add(SEL_B, 1, 1, 0, 0, 0, 1, 0);
        add(SEL_B, 1, 0, 0, 0, 0, 1, 0);
        // en gating: junk din on disabled cycles, match held while en=0
        add(SEL_A, 1, 0, 1, 1, 0, 0, 0);
        add(SEL_A, 1, 1, 1, 0, 0, 0, 0);
        add(SEL_A, 0, 0, 1, 0, 0, 0, 0);
        add(SEL_A, 1, 1, 1, 0, 0, 0, 0);
        add(SEL_A, 0, 0, 1, 0, 0, 0, 0);
        add(SEL_A, 1, 0, 1, 0, 0, 0, 0);
        add(SEL_A, 0, 1, 1, 0, 0, 0, 0);
        add(SEL_A, 1, 0, 1, 0, 1, 1, 0);
        add(SEL_A, 0, 1, 1, 0, 1, 1, 0);
        add(SEL_A, 0, 0, 1, 0, 1, 1, 0);
        add(SEL_A, 1, 1, 1, 0, 0, 1, 0);
        // 2-bit counter: nine back-to-back 1100 saturate at 3, then clear
        add(SEL_C, 1, 0, 1, 1, 0, 0, 0);
        for (int p = 0; p < 9; p++) begin
            c = (p < 3) ? p : 3;
            add(SEL_C, 1, 1, 1, 0, 0, c, c == 3);
            add(SEL_C, 1, 1, 1, 0, 0, c, c == 3);
            add(SEL_C, 1, 0, 1, 0, 0, c, c == 3);
            c = (p + 1 < 3) ? p + 1 : 3;
            add(SEL_C, 1, 0, 1, 0, 1, c, c == 3);
        end
        add(SEL_C, 1, 1, 1, 1, 0, 0, 0);
        // clear together with the completing bit: no match, no count
        add(SEL_A, 1, 0, 1, 1, 0, 0, 0);
        add(SEL_A, 1, 1, 1, 0, 0, 0, 0);
        add(SEL_A, 1, 1, 1, 0, 0, 0, 0);
        add(SEL_A, 1, 0, 1, 0, 0, 0, 0);
        add(SEL_A, 1, 0, 1, 1, 0, 0, 0);
        add(SEL_A, 1, 0, 1, 0, 0, 0, 0);

        // Reset state
        #3;
        chk("rst_match_a", int'(ma), 0);
        chk("rst_count_a", int'(ca), 0);
        chk("rst_sat_a", int'(sa), 0);
        chk("rst_match_b", int'(mb), 0);
        chk("rst_count_c", int'(cc), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < nv; i++) begin
            apply(vt[i].sel, vt[i].en, vt[i].din, vt[i].ovl, vt[i].clr,
                  vt[i].em, vt[i].ec, vt[i].es);
        end

        // Async reset mid-pattern after one counted match
        apply(SEL_A, 1, 1, 1, 0, 0, 0, 0);
        apply(SEL_A, 1, 1, 1, 0, 0, 0, 0);
        apply(SEL_A, 1, 0, 1, 0, 0, 0, 0);
        apply(SEL_A, 1, 0, 1, 0, 1, 1, 0);
        apply(SEL_A, 1, 1, 1, 0, 0, 1, 0);
        apply(SEL_A, 1, 1, 1, 0, 0, 1, 0);
        apply(SEL_A, 1, 0, 1, 0, 0, 1, 0);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_count", int'(ca), 0);
        chk("async_rst_match", int'(ma), 0);
        #1 reset = 1'b0;
        apply(SEL_A, 1, 0, 1, 0, 0, 0, 0);
        apply(SEL_A, 1, 1, 1, 0, 0, 0, 0);
        apply(SEL_A, 1, 1, 1, 0, 0, 0, 0);
        apply(SEL_A, 1, 0, 1, 0, 0, 0, 0);
        apply(SEL_A, 1, 0, 1, 0, 1, 1, 0);

        chk("scoreboard_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_detector.md
# seq_detector

Parametrised, overlapping-capable serial pattern detector built as a Moore state machine. It samples one bit per enabled clock and compares the stream against a compile-time pattern of configurable length. It asserts a registered match flag while the pattern has just completed, and keeps a saturating count of matches. The block sits behind the debounced push-button or serial input path and generalises the fixed 4-bit "1100" detector to any pattern, with an overlap mode, sample enable, clear and counter.

## Interface
- PAT_LEN, 4: pattern length in bits, legal range 2..16.
- PATTERN, 4'b1100: pattern bits, width PAT_LEN; PATTERN[PAT_LEN-1] is the first bit expected.
- CNT_W, 8: match counter width, legal range 1..16.

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- en  in  1  sample strobe; din is consumed only on edges where en=1.
- din  in  1  serial data bit.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping; sampled with din.
- clear  in  1  synchronous clear of state and counter.
- match  out  1  Moore output, high while state == PAT_LEN.
- match_count  out  CNT_W  number of matches since reset/clear, saturating.
- count_sat  out  1  high when match_count == 2^CNT_W-1.

## Operation
- State s is the length of the pattern prefix currently matched, in 0..PAT_LEN. It is encoded in $clog2(PAT_LEN+1) bits.
- Reset (async) or clear (sync): s=0, match=0, match_count=0, count_sat=0.
- Priority on an edge is reset > clear > en. With en=0 and clear=0, all registers hold, so match stays at its current value.
- Transition on en=1 with s<PAT_LEN: s_next is the longest prefix of PATTERN that is a suffix of (first s pattern bits followed by din). This is the KMP failure function.
- Transition on en=1 with s==PAT_LEN:
  - overlap=1: same rule as above, so the matched pattern's border is retained.
  - overlap=0: history is discarded. s_next=1 if din==PATTERN[PAT_LEN-1], else s_next=0.
- match = (s == PAT_LEN). It is decoded from the registered state only and is glitch-free with respect to din.
- match_count increments by 1 on every enabled edge where s_next==PAT_LEN.
  - If it is already saturated, it holds at 2^CNT_W-1.
  - Two consecutive matches each count.
- Illegal state encodings (> PAT_LEN) return to s=0 on the next enabled edge; match is 0 while in them.

## Timing
- Latency: match rises one clock after the enabled edge that consumes the final pattern bit. match_count updates on that same edge.
- match stays high for exactly one enabled sample when en is held high. It stays high longer if en drops while s==PAT_LEN.
- overlap may change on any cycle; it affects only the transition it is sampled with.
- clear in the same cycle as a completing bit: the clear wins, and the count is not incremented.
- Reset asserted mid-pattern: all outputs go to 0 immediately (asynchronously). Release is synchronous to clk.

## Structure
- Package seq_det_pkg holds:
  - the function next_state(pattern, len, s, bit) implementing the prefix/suffix rule;
  - the helper state_w(len) = $clog2(len+1).
- The transition table is elaborated at compile time from PATTERN. There is no runtime pattern search.
- One sub-module, sat_counter (parameter W; ports clk, reset, clr, inc, q, sat), holds the match counter.

## Test plan
- Defaults (PATTERN=1100), en=1, din 1,1,0,0,1,1,0,0 -> match high in the cycles after samples 4 and 8; match_count=2.
- PATTERN=4'b1010:
  - overlap=1, din 1,0,1,0,1,0 -> matches after samples 4 and 6; match_count=2.
  - overlap=0, same stream -> match after sample 4 only; match_count=1.
- en gating: the 1100 stream with en=0 on alternate cycles -> the same matches, delayed; while en=0 after a completed match, match stays high.
- CNT_W=2, nine back-to-back 1100 patterns -> match_count stops at 3 with count_sat=1; clear -> both 0 on the next clock.
- After din 1,1,0 (s=3):
  - reset pulse, then 0 -> no match; s restarts from 0.
  - Alternatively clear in the same cycle as the final 0 -> match stays 0 and the count is unchanged.
